// File: rtl/conv_window_scheduler_pkg.sv
// Shared definitions for the 3x3 convolution window scheduler: tap geometry,
// FSM encoding and the padding / row-wrap helpers used by the address generator.
package conv_window_scheduler_pkg;

   localparam int NUM_TAPS     = 9;
   localparam int TAPS_PER_ROW = 3;

   typedef enum logic [1:0] {
      StIdle,
      StWaitRows,
      StRun,
      StDone
   } state_e;

   // Tap k = 8 is the top-left corner of the window, tap 0 the bottom-right.
   function automatic int tap_dy(input int k);
      return (NUM_TAPS - 1 - k) / TAPS_PER_ROW;
   endfunction

   function automatic int tap_dx(input int k);
      return (NUM_TAPS - 1 - k) % TAPS_PER_ROW;
   endfunction

   function automatic logic tap_in_range(input int src, input int lim);
      return (src >= 0) && (src < lim);
   endfunction

   // Source row offset is at most one step outside [0, depth), so one compare
   // per side replaces a modulo.
   function automatic int wrap_row(input int r, input int depth);
      if (r < 0) begin
         return r + depth;
      end
      if (r >= depth) begin
         return r - depth;
      end
      return r;
   endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Configuration, credit and window bus between the scheduler and the
// line-buffer read control / PE array.
interface conv_window_scheduler_if #(
   parameter int unsigned width_b  = 7,
   parameter int unsigned height_b = 3
) ();

   logic                     start;
   logic [width_b-1:0]       cfg_w;
   logic [7:0]               cfg_h;
   logic [2:0]               cfg_c;
   logic                     row_done;
   logic                     stall;
   logic [width_b*9-1:0]     readi_wr;
   logic [height_b*9-1:0]    readi_hr;
   logic [8:0]               en_read;
   logic                     en_bias;
   logic [2:0]               stepr;
   logic                     en_pe;
   logic                     row_free;
   logic                     busy;
   logic                     done;

   modport master (
      input  start, cfg_w, cfg_h, cfg_c, row_done, stall,
      output readi_wr, readi_hr, en_read, en_bias, stepr, en_pe, row_free, busy, done
   );

   modport slave (
      output start, cfg_w, cfg_h, cfg_c, row_done, stall,
      input  readi_wr, readi_hr, en_read, en_bias, stepr, en_pe, row_free, busy, done
   );

endinterface

// File: rtl/conv_tap_addr_gen.sv
// Combinational mapping of an output pixel to its 9 line-buffer tap addresses
// and the zero-padding mask. Padded taps carry all-zero addresses.
module conv_tap_addr_gen
   import conv_window_scheduler_pkg::*;
#(
   parameter int unsigned width_b  = 7,
   parameter int unsigned height   = 8,
   parameter int unsigned height_b = 3
) (
   input  logic [7:0]             y,
   input  logic [height_b-1:0]    y_mod,
   input  logic [width_b-1:0]     x,
   input  logic [width_b-1:0]     cfg_w,
   input  logic [7:0]             cfg_h,
   output logic [width_b*9-1:0]   col_addr,
   output logic [height_b*9-1:0]  row_addr,
   output logic [8:0]             tap_en
);

   // Per-tap bounds check against the frame, then address into the circular buffer.
   always_comb begin
      col_addr = '0;
      row_addr = '0;
      tap_en   = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         if (tap_in_range(int'(y) + tap_dy(k) - 1, int'(cfg_h)) &&
             tap_in_range(int'(x) + tap_dx(k) - 1, int'(cfg_w))) begin
            tap_en[k] = 1'b1;
            col_addr[k*width_b +: width_b] = width_b'(int'(x) + tap_dx(k) - 1);
            row_addr[k*height_b +: height_b] =
               height_b'(wrap_row(int'(y_mod) + tap_dy(k) - 1, int'(height)));
         end
      end
   end

endmodule

// File: rtl/conv_window_scheduler.sv
// Raster-order window sequencer for a stride-1, pad-1 3x3 convolution. Loops
// channel groups per pixel, paces rows against write-side credits and returns
// row-free pulses. All outputs are registered.
module conv_window_scheduler
   import conv_window_scheduler_pkg::*;
#(
   parameter int unsigned width    = 80,
   parameter int unsigned height   = 8,
   parameter int unsigned width_b  = 7,
   parameter int unsigned height_b = 3
) (
   input logic                     clk,
   input logic                     reset,
   conv_window_scheduler_if.master bus
);

   state_e                  state_q;
   logic [width_b-1:0]      cfg_w_q, x_q;
   logic [7:0]              cfg_h_q, y_q, rows_loaded_q;
   logic [2:0]              cfg_c_q, c_q;
   logic [height_b-1:0]     y_mod_q;

   logic [width_b*9-1:0]    readi_wr_q;
   logic [height_b*9-1:0]   readi_hr_q;
   logic [8:0]              en_read_q;
   logic [2:0]              stepr_q;
   logic                    en_bias_q, en_pe_q, row_free_q, busy_q, done_q;

   logic [width_b*9-1:0]    tap_col;
   logic [height_b*9-1:0]   tap_row;
   logic [8:0]              tap_en;

   logic [7:0]              rows_avail;
   logic [8:0]              y_plus2, y_plus3, need_cur, need_next;
   logic                    credit_cur, credit_next, last_c, last_x, last_y;
   logic [height_b-1:0]     y_mod_inc;

   // Credit bookkeeping and loop-end decodes; a row_done this cycle already counts.
   always_comb begin
      rows_avail = rows_loaded_q;
      if (bus.row_done && (state_q != StIdle) && (rows_loaded_q < cfg_h_q)) begin
         rows_avail = rows_loaded_q + 8'd1;
      end
      y_plus2     = {1'b0, y_q} + 9'd2;
      y_plus3     = {1'b0, y_q} + 9'd3;
      need_cur    = (y_plus2 > {1'b0, cfg_h_q}) ? {1'b0, cfg_h_q} : y_plus2;
      need_next   = (y_plus3 > {1'b0, cfg_h_q}) ? {1'b0, cfg_h_q} : y_plus3;
      credit_cur  = ({1'b0, rows_avail} >= need_cur);
      credit_next = ({1'b0, rows_avail} >= need_next);
      last_c      = (c_q == cfg_c_q);
      last_x      = (x_q == cfg_w_q - width_b'(1));
      last_y      = (y_q == cfg_h_q - 8'd1);
      y_mod_inc   = (y_mod_q == height_b'(height - 1)) ? '0 : y_mod_q + height_b'(1);
   end

   conv_tap_addr_gen #(
      .width_b  (width_b),
      .height   (height),
      .height_b (height_b)
   ) u_tap_addr_gen (
      .y        (y_q),
      .y_mod    (y_mod_q),
      .x        (x_q),
      .cfg_w    (cfg_w_q),
      .cfg_h    (cfg_h_q),
      .col_addr (tap_col),
      .row_addr (tap_row),
      .tap_en   (tap_en)
   );

   // FSM, loop counters, credit counter and registered window outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         cfg_w_q       <= '0;
         cfg_h_q       <= '0;
         cfg_c_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         c_q           <= '0;
         y_mod_q       <= '0;
         rows_loaded_q <= '0;
         readi_wr_q    <= '0;
         readi_hr_q    <= '0;
         en_read_q     <= '0;
         stepr_q       <= '0;
         en_bias_q     <= 1'b0;
         en_pe_q       <= 1'b0;
         row_free_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         en_pe_q       <= 1'b0;
         en_read_q     <= '0;
         en_bias_q     <= 1'b0;
         row_free_q    <= 1'b0;
         done_q        <= 1'b0;
         rows_loaded_q <= rows_avail;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  // Out-of-range sizes are clamped so the scan always terminates.
                  cfg_w_q <= (bus.cfg_w == '0) ? width_b'(1) :
                             ((int'(bus.cfg_w) > int'(width)) ? width_b'(width) : bus.cfg_w);
                  cfg_h_q       <= (bus.cfg_h == 8'd0) ? 8'd1 : bus.cfg_h;
                  cfg_c_q       <= bus.cfg_c;
                  x_q           <= '0;
                  y_q           <= '0;
                  c_q           <= '0;
                  y_mod_q       <= '0;
                  rows_loaded_q <= '0;
                  busy_q        <= 1'b1;
                  state_q       <= StWaitRows;
               end
            end
            StWaitRows: begin
               if (credit_cur) begin
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (!bus.stall) begin
                  en_pe_q    <= 1'b1;
                  en_read_q  <= tap_en;
                  readi_wr_q <= tap_col;
                  readi_hr_q <= tap_row;
                  stepr_q    <= c_q;
                  en_bias_q  <= (c_q == 3'd0);
                  if (!last_c) begin
                     c_q <= c_q + 3'd1;
                  end else begin
                     c_q <= '0;
                     if (!last_x) begin
                        x_q <= x_q + width_b'(1);
                     end else begin
                        x_q <= '0;
                        // Row y-1 is no longer referenced once row y is complete.
                        row_free_q <= (y_q != 8'd0);
                        if (last_y) begin
                           state_q <= StDone;
                        end else begin
                           y_q     <= y_q + 8'd1;
                           y_mod_q <= y_mod_inc;
                           if (!credit_next) begin
                              state_q <= StWaitRows;
                           end
                        end
                     end
                  end
               end
            end
            StDone: begin
               done_q     <= 1'b1;
               row_free_q <= 1'b1;  // release the remaining rows of the frame
               busy_q     <= 1'b0;
               state_q    <= StIdle;
            end
         endcase
      end
   end

   assign bus.readi_wr = readi_wr_q;
   assign bus.readi_hr = readi_hr_q;
   assign bus.en_read  = en_read_q;
   assign bus.en_bias  = en_bias_q;
   assign bus.stepr    = stepr_q;
   assign bus.en_pe    = en_pe_q;
   assign bus.row_free = row_free_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: a frame-level window model (expected
// window list from source-coordinate rules) checked on every output cycle,
// plus literal expectations for corner windows.
module tb_conv_window_scheduler;

   localparam int W_B   = 7;
   localparam int H_B   = 3;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   conv_window_scheduler_if #(.width_b(W_B), .height_b(H_B)) bus ();

   conv_window_scheduler #(
      .width    (80),
      .height   (DEPTH),
      .width_b  (W_B),
      .height_b (H_B)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [W_B*9-1:0] wr;
      logic [H_B*9-1:0] hr;
      logic [8:0]       en;
      logic [2:0]       step;
      logic             bias;
      int               y;
      int               x;
   } win_t;

   win_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   credits = 0;
   int   cur_h = 1;
   int   win_idx, pe_cnt, rf_cnt, done_cnt;
   int   frame_id = -1;
   bit   aborted, frame_end;
   logic [8:0]       en_first, en_last;
   logic [H_B*9-1:0] hr_y8;
   logic [2:0]       step_seq [3];
   logic             bias_seq [3];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Expected window stream: c fastest, then x, then y; taps from source coordinates.
   task automatic build_expected(input int w, input int h, input int c);
      win_t e;
      exp_q.delete();
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            for (int cc = 0; cc <= c; cc++) begin
               e.wr = '0; e.hr = '0; e.en = '0;
               e.step = 3'(cc); e.bias = (cc == 0); e.y = y; e.x = x;
               for (int k = 0; k < 9; k++) begin
                  int t, sr, sc;
                  t  = 8 - k;
                  sr = y + t / 3 - 1;
                  sc = x + t % 3 - 1;
                  if (sr >= 0 && sr < h && sc >= 0 && sc < w) begin
                     e.en[k] = 1'b1;
                     e.wr[k*W_B +: W_B] = W_B'(sc);
                     e.hr[k*H_B +: H_B] = H_B'(sr % DEPTH);
                  end
               end
               exp_q.push_back(e);
            end
         end
      end
   endtask

   // Compare process: every issued window against the model, credit rule, idle taps.
   always @(negedge clk) begin : monitor
      win_t e;
      int   need;
      if (!reset) begin
         if (bus.en_pe) begin
            if (exp_q.size() == 0) begin
               check("extra_window", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("en_read", 64'(bus.en_read), 64'(e.en));
               check("readi_wr", 64'(bus.readi_wr), 64'(e.wr));
               check("readi_hr", 64'(bus.readi_hr), 64'(e.hr));
               check("stepr", 64'(bus.stepr), 64'(e.step));
               check("en_bias", 64'(bus.en_bias), 64'(e.bias));
               need = (e.y + 2 < cur_h) ? e.y + 2 : cur_h;
               check("credit", 64'(credits >= need), 64'd1);
               if (win_idx == 0) en_first = bus.en_read;
               if (win_idx == 15) en_last = bus.en_read;
               if (frame_id == 3 && e.y == 8 && e.x == 1) hr_y8 = bus.readi_hr;
               if (frame_id == 2 && win_idx < 3) begin
                  step_seq[win_idx] = bus.stepr;
                  bias_seq[win_idx] = bus.en_bias;
               end
               win_idx++;
               pe_cnt++;
            end
         end else begin
            check("idle_taps", 64'({bus.en_read, bus.en_bias}), 64'd0);
         end
         if (bus.row_free) rf_cnt++;
         if (bus.done) begin
            done_cnt++;
            frame_end = 1'b1;
         end
         if (bus.row_done && bus.busy && credits < cur_h) credits++;
      end
   end

   task automatic run_frame(input int w, input int h, input int c, input int gap,
                            input int stall_at, input int reset_at, input int poke_at);
      build_expected(w, h, c);
      win_idx = 0; pe_cnt = 0; rf_cnt = 0; done_cnt = 0;
      aborted = 1'b0; frame_end = 1'b0;
      @(posedge clk); #1;
      bus.cfg_w = W_B'(w); bus.cfg_h = 8'(h); bus.cfg_c = 3'(c);
      bus.start = 1'b1; cur_h = h; credits = 0;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk); check("busy_after_start", 64'(bus.busy), 64'd1);
      fork
         begin
            for (int i = 0; i < h && !aborted; i++) begin
               repeat (gap) @(posedge clk);
               #1 bus.row_done = 1'b1;
               @(posedge clk);
               #1 bus.row_done = 1'b0;
            end
         end
         begin
            for (int n = 0; n < 4000 && !frame_end && !aborted; n++) @(negedge clk);
            if (!frame_end && !aborted) check("frame_timeout", 64'd0, 64'd1);
         end
         begin
            if (stall_at >= 0) begin
               for (int n = 0; n < 4000 && win_idx < stall_at; n++) @(negedge clk);
               @(posedge clk); #1 bus.stall = 1'b1;
               @(posedge clk);
               @(negedge clk); check("stall_hold", 64'(bus.en_pe), 64'd0);
               @(negedge clk); check("stall_hold", 64'(bus.en_pe), 64'd0);
               @(posedge clk); #1 bus.stall = 1'b0;
               @(negedge clk); check("stall_hold", 64'(bus.en_pe), 64'd0);
            end
         end
         begin
            if (reset_at >= 0) begin
               for (int n = 0; n < 4000 && win_idx < reset_at; n++) @(negedge clk);
               @(posedge clk); #1 reset = 1'b1;
               @(posedge clk); #1 reset = 1'b0;
               aborted = 1'b1; exp_q.delete(); credits = 0;
               @(negedge clk);
               check("rst_ctrl", 64'({bus.en_pe, bus.en_read, bus.en_bias, bus.stepr,
                                     bus.row_free, bus.busy, bus.done}), 64'd0);
               check("rst_wr", 64'(bus.readi_wr), 64'd0);
               check("rst_hr", 64'(bus.readi_hr), 64'd0);
               repeat (6) @(negedge clk);
               check("no_done_after_reset", 64'(done_cnt), 64'd0);
            end
         end
         begin
            if (poke_at > 0) begin
               repeat (poke_at) @(posedge clk);
               #1 check("busy_at_poke", 64'(bus.busy), 64'd1);
               bus.start = 1'b1; bus.cfg_w = W_B'(2); bus.cfg_c = 3'd5;
               @(posedge clk);
               #1 bus.start = 1'b0; bus.cfg_w = W_B'(w); bus.cfg_c = 3'(c);
            end
         end
      join
      if (reset_at < 0) begin
         repeat (4) @(negedge clk);
         check("window_count", 64'(pe_cnt), 64'(w * h * (c + 1)));
         check("row_free_count", 64'(rf_cnt), 64'(h));
         check("done_count", 64'(done_cnt), 64'd1);
         check("model_drained", 64'(exp_q.size()), 64'd0);
         check("idle_after_frame", 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not end (checks=%0d errors=%0d)", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.cfg_w = '0; bus.cfg_h = '0; bus.cfg_c = '0;
      bus.row_done = 1'b0; bus.stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_ctrl", 64'({bus.en_pe, bus.en_read, bus.en_bias, bus.stepr,
                               bus.row_free, bus.busy, bus.done}), 64'd0);
      check("reset_wr", 64'(bus.readi_wr), 64'd0);
      check("reset_hr", 64'(bus.readi_hr), 64'd0);

      frame_id = 0;  // 4x4, credits arrive quickly
      run_frame(4, 4, 0, 1, -1, -1, 0);
      check("pin_win_0_0", 64'(en_first), 64'(9'b000_011_011));
      check("pin_win_3_3", 64'(en_last), 64'(9'b110_110_000));

      frame_id = 1;  // slow credits, ignored start while busy
      run_frame(4, 4, 0, 20, -1, -1, 30);

      frame_id = 2;  // channel-group loop
      run_frame(3, 2, 2, 1, -1, -1, 0);
      for (int i = 0; i < 3; i++) begin
         check("pin_stepr_seq", 64'(step_seq[i]), 64'(i));
         check("pin_bias_seq", 64'(bias_seq[i]), 64'(i == 0));
      end

      frame_id = 3;  // taller than the line buffer
      run_frame(4, 12, 0, 3, -1, -1, 0);
      check("pin_wrap_dy0", 64'(hr_y8[7*H_B +: H_B]), 64'd7);
      check("pin_wrap_dy2", 64'(hr_y8[1*H_B +: H_B]), 64'd1);

      frame_id = 4;  // stall mid-row
      run_frame(4, 3, 1, 1, 3, -1, 0);

      frame_id = 5;  // reset mid-frame, then a clean rerun
      run_frame(4, 4, 0, 1, -1, 5, 0);
      frame_id = 6;
      en_first = '0; en_last = '0;
      run_frame(4, 4, 0, 1, -1, -1, 0);
      check("rerun_win_0_0", 64'(en_first), 64'(9'b000_011_011));
      check("rerun_win_3_3", 64'(en_last), 64'(9'b110_110_000));

      frame_id = 7;  // 1x1 frame: only the centre tap survives
      run_frame(1, 1, 0, 1, -1, -1, 0);
      check("pin_1x1_mask", 64'(en_first), 64'(9'b000_010_000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
